// File: rtl/tetris_pkg.sv
// Shared types for the Tetris move scheduler: command opcodes, joystick direction
// and horizontal auto-shift states, plus a width helper for the repeat counters.
package tetris_pkg;

  typedef enum logic [1:0] {
    CMD_LEFT  = 2'b00,
    CMD_RIGHT = 2'b01,
    CMD_DOWN  = 2'b10,
    CMD_ROT   = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    H_IDLE,
    H_DAS,
    H_REPEAT
  } hfsm_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tetris_debounce.sv
// Two-flop synchroniser followed by a counter debouncer: the output level follows
// the button only after DEBOUNCE_CYC consecutive samples disagree with it.
module tetris_debounce #(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, as the hardware does.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/tetris_move_scheduler.sv
// Converts joystick X samples and rotate/drop buttons into LEFT/RIGHT/DOWN/ROT
// commands with DAS/ARR auto-shift, soft-drop repeat and a valid/ready output.
module tetris_move_scheduler
  import tetris_pkg::*;
#(
  parameter int ADC_W        = 12,
  parameter int LEFT_THRESH  = 1024,
  parameter int RIGHT_THRESH = 3072,
  parameter int HYST         = 128,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int DAS_DELAY    = 8_000_000,
  parameter int ARR_PERIOD   = 2_500_000,
  parameter int DROP_PERIOD  = 2_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [ADC_W-1:0] adc_x,
  input  logic             adc_valid,
  input  logic             btn_rotate,
  input  logic             btn_drop,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [1:0]       cmd_op,
  output logic             soft_drop
);

  localparam int HCW = $clog2(max_int(DAS_DELAY, ARR_PERIOD) + 1);
  localparam int DCW = $clog2(DROP_PERIOD + 1);

  localparam logic [ADC_W-1:0] LEFT_ON   = ADC_W'(LEFT_THRESH);
  localparam logic [ADC_W-1:0] LEFT_OFF  = ADC_W'(LEFT_THRESH + HYST);
  localparam logic [ADC_W-1:0] RIGHT_ON  = ADC_W'(RIGHT_THRESH);
  localparam logic [ADC_W-1:0] RIGHT_OFF = ADC_W'(RIGHT_THRESH - HYST);

  logic rot_lvl, drop_lvl;
  logic rot_prev_q, drop_prev_q;
  dir_t dir_q, dir_d, dir_prev_q;
  hfsm_t hstate_q, hstate_d;
  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic drop_act_q, drop_act_d;
  logic pend_rot_q, pend_rot_d, pend_h_q, pend_h_d, pend_down_q, pend_down_d;
  logic cmd_valid_q, cmd_valid_d, soft_drop_q, soft_drop_d;
  cmd_op_t cmd_op_q, cmd_op_d;
  logic set_rot, set_h, set_down, h_req, dir_trig;

  tetris_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_rot (
    .clk(clk), .reset_n(reset_n), .btn_i(btn_rotate), .level_o(rot_lvl));
  tetris_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_drop (
    .clk(clk), .reset_n(reset_n), .btn_i(btn_drop), .level_o(drop_lvl));

  // Shifts fire on the event of dir leaving NONE, so a re-enable while the
  // stick is still deflected does not produce a spurious move.
  assign dir_trig = (dir_q != DIR_NONE) && (dir_prev_q == DIR_NONE);
  assign h_req    = pend_h_q && (dir_q != DIR_NONE);
  assign set_rot  = enable && rot_lvl && !rot_prev_q;

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would otherwise infer a latch.
  always_comb begin
    dir_d = dir_q;
    if (adc_valid) begin
      case (dir_q)
        DIR_NONE:  if (adc_x < LEFT_ON) dir_d = DIR_LEFT;
                   else if (adc_x > RIGHT_ON) dir_d = DIR_RIGHT;
        DIR_LEFT:  if (adc_x >= LEFT_OFF) dir_d = DIR_NONE;
        DIR_RIGHT: if (adc_x <= RIGHT_OFF) dir_d = DIR_NONE;
        default:   dir_d = DIR_NONE;
      endcase
    end

    set_h    = 1'b0;
    hstate_d = hstate_q;
    hcnt_d   = hcnt_q;
    if (!enable || dir_q == DIR_NONE) begin
      hstate_d = H_IDLE;
    end else if (dir_trig) begin
      set_h    = 1'b1;
      hcnt_d   = HCW'(DAS_DELAY - 1);
      hstate_d = H_DAS;
    end else if (hstate_q != H_IDLE) begin
      if (hcnt_q == '0) begin
        set_h    = 1'b1;
        hcnt_d   = HCW'(ARR_PERIOD - 1);
        hstate_d = H_REPEAT;
      end else begin
        hcnt_d = hcnt_q - 1'b1;
      end
    end

    set_down   = 1'b0;
    drop_act_d = drop_act_q;
    dcnt_d     = dcnt_q;
    if (!enable || !drop_lvl) begin
      drop_act_d = 1'b0;
    end else if (!drop_prev_q) begin
      set_down   = 1'b1;
      drop_act_d = 1'b1;
      dcnt_d     = DCW'(DROP_PERIOD - 1);
    end else if (drop_act_q) begin
      if (dcnt_q == '0) begin
        set_down = 1'b1;
        dcnt_d   = DCW'(DROP_PERIOD - 1);
      end else begin
        dcnt_d = dcnt_q - 1'b1;
      end
    end

    // Arbitration: rotate > horizontal > down; a new request wins over the clear.
    pend_rot_d  = pend_rot_q;
    pend_h_d    = h_req;
    pend_down_d = pend_down_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    if (!enable) begin
      pend_rot_d  = 1'b0;
      pend_h_d    = 1'b0;
      pend_down_d = 1'b0;
      cmd_valid_d = 1'b0;
    end else begin
      if (!cmd_valid_q || cmd_ready) begin
        cmd_valid_d = 1'b1;
        if (pend_rot_q) begin
          cmd_op_d   = CMD_ROT;
          pend_rot_d = 1'b0;
        end else if (h_req) begin
          cmd_op_d = (dir_q == DIR_LEFT) ? CMD_LEFT : CMD_RIGHT;
          pend_h_d = 1'b0;
        end else if (pend_down_q) begin
          cmd_op_d    = CMD_DOWN;
          pend_down_d = 1'b0;
        end else begin
          cmd_valid_d = 1'b0;
        end
      end
      pend_rot_d  = pend_rot_d | set_rot;
      pend_h_d    = pend_h_d | set_h;
      pend_down_d = pend_down_d | set_down;
    end

    soft_drop_d = drop_lvl && enable;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rot_prev_q  <= 1'b0;
      drop_prev_q <= 1'b0;
      dir_q       <= DIR_NONE;
      dir_prev_q  <= DIR_NONE;
      hstate_q    <= H_IDLE;
      hcnt_q      <= '0;
      dcnt_q      <= '0;
      drop_act_q  <= 1'b0;
      pend_rot_q  <= 1'b0;
      pend_h_q    <= 1'b0;
      pend_down_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= CMD_LEFT;
      soft_drop_q <= 1'b0;
    end else begin
      rot_prev_q  <= rot_lvl;
      drop_prev_q <= drop_lvl;
      dir_q       <= dir_d;
      dir_prev_q  <= dir_q;
      hstate_q    <= hstate_d;
      hcnt_q      <= hcnt_d;
      dcnt_q      <= dcnt_d;
      drop_act_q  <= drop_act_d;
      pend_rot_q  <= pend_rot_d;
      pend_h_q    <= pend_h_d;
      pend_down_q <= pend_down_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      soft_drop_q <= soft_drop_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign soft_drop = soft_drop_q;

endmodule
